// File: rtl/hls_fu_pkg.sv
// Shared definitions for the HLS arithmetic functional units.
// Holds the default datapath width, the pipeline depth limit and the common result record.
package hls_fu_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int MAX_STAGES    = 4;

   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] sum;
      logic                     carry;
      logic                     ovf;
   } fu_result_t;

endpackage

// File: rtl/hls_add_unit_if.sv
// Operand/result handshake bundle between a datapath and the add unit.
// The master drives operands and result-ready; the slave (the unit) drives results and in_ready.
interface hls_add_unit_if
   import hls_fu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out;
   logic             out_carry;
   logic             out_ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in0, in1, in_valid, out_ready,
      input  in_ready, out, out_carry, out_ovf, out_valid
   );

   modport slave (
      input  in0, in1, in_valid, out_ready,
      output in_ready, out, out_carry, out_ovf, out_valid
   );

endinterface

// File: rtl/add_seg_stage.sv
// One SEG-bit slice of the carry chain: registers sum and carry-out when enabled; latency 1.
// Backpressure: holds its registers while en is low.
module add_seg_stage
   import hls_fu_pkg::*;
#(
   parameter int SEG = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           cin,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   output logic [SEG-1:0] sum,
   output logic           cout
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (en) begin
         {cout, sum} <= {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
      end
   end

endmodule

// File: rtl/hls_add_unit.sv
// Pipelined adder with carry-out and signed overflow; latency STAGES, one pair per cycle.
// Backpressure: global advance, the whole pipe freezes while out_valid && !out_ready.
module hls_add_unit
   import hls_fu_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = 1
) (
   input  logic          clk,
   input  logic          rst,
   hls_add_unit_if.slave bus
);

   localparam int SEG = WIDTH / STAGES;

   if ((STAGES < 1) || (STAGES > MAX_STAGES) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("hls_add_unit: WIDTH must be a multiple of STAGES and STAGES must be 1..4");
   end

   logic              adv;
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] en;
   logic [STAGES-1:0] cout;
   logic [WIDTH-1:0]  sum;
   logic [1:0]        msb_q [STAGES];

   assign adv          = !vld[STAGES-1] || bus.out_ready;
   assign bus.in_ready = adv;

   // A slot only loads when a real token enters it, so bubbles leave old results in place.
   always_comb begin
      en    = '0;
      en[0] = adv && bus.in_valid;
      for (int p = 1; p < STAGES; p++) en[p] = adv && vld[p-1];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld <= '0;
         for (int p = 0; p < STAGES; p++) msb_q[p] <= '0;
      end else begin
         if (adv) begin
            vld[0] <= bus.in_valid;
            for (int p = 1; p < STAGES; p++) vld[p] <= vld[p-1];
         end
         if (en[0]) msb_q[0] <= {bus.in0[WIDTH-1], bus.in1[WIDTH-1]};
         for (int p = 1; p < STAGES; p++) begin
            if (en[p]) msb_q[p] <= msb_q[p-1];
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      logic [SEG-1:0] a_seg;
      logic [SEG-1:0] b_seg;
      logic [SEG-1:0] s_seg;
      logic           cin;

      if (k == 0) begin : g_head
         assign a_seg = bus.in0[SEG-1:0];
         assign b_seg = bus.in1[SEG-1:0];
         assign cin   = 1'b0;
      end else begin : g_skew
         // Upper operand slices wait k slots so they meet the carry from the slice below.
         logic [SEG-1:0] a_q [k];
         logic [SEG-1:0] b_q [k];

         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int i = 0; i < k; i++) begin
                  a_q[i] <= '0;
                  b_q[i] <= '0;
               end
            end else begin
               if (en[0]) begin
                  a_q[0] <= bus.in0[k*SEG +: SEG];
                  b_q[0] <= bus.in1[k*SEG +: SEG];
               end
               for (int p = 1; p < k; p++) begin
                  if (en[p]) begin
                     a_q[p] <= a_q[p-1];
                     b_q[p] <= b_q[p-1];
                  end
               end
            end
         end

         assign a_seg = a_q[k-1];
         assign b_seg = b_q[k-1];
         assign cin   = cout[k-1];
      end

      add_seg_stage #(.SEG(SEG)) u_stage (
         .clk  (clk),
         .rst  (rst),
         .en   (en[k]),
         .cin  (cin),
         .a    (a_seg),
         .b    (b_seg),
         .sum  (s_seg),
         .cout (cout[k])
      );

      if (k == STAGES-1) begin : g_tail
         assign sum[k*SEG +: SEG] = s_seg;
      end else begin : g_deskew
         localparam int D = STAGES - 1 - k;
         logic [SEG-1:0] s_q [D];

         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int j = 0; j < D; j++) s_q[j] <= '0;
            end else begin
               if (en[k+1]) s_q[0] <= s_seg;
               for (int j = 1; j < D; j++) begin
                  if (en[k+1+j]) s_q[j] <= s_q[j-1];
               end
            end
         end

         assign sum[k*SEG +: SEG] = s_q[D-1];
      end
   end

   assign bus.out       = sum;
   assign bus.out_carry = cout[STAGES-1];
   assign bus.out_valid = vld[STAGES-1];
   assign bus.out_ovf   = (msb_q[STAGES-1][1] == msb_q[STAGES-1][0]) &&
                          (sum[WIDTH-1] != msb_q[STAGES-1][1]);

endmodule

// File: tb/tb_hls_add_unit.sv
// Bench for hls_add_unit: five width/depth configurations, directed vectors plus a random scoreboard run.
module tb_hls_add_unit;

   localparam int NC = 5;

   function automatic int cfg_w(input int g);
      case (g)
         3:       return 16;
         4:       return 48;
         default: return 32;
      endcase
   endfunction

   function automatic int cfg_s(input int g);
      case (g)
         0:       return 1;
         1:       return 2;
         4:       return 3;
         default: return 4;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] drv_a    [NC];
   logic [63:0] drv_b    [NC];
   logic        drv_vld  [NC];
   logic        drv_ordy [NC];
   logic [63:0] obs_out  [NC];
   logic        obs_vld  [NC];
   logic        obs_rdy  [NC];
   logic        obs_c    [NC];
   logic        obs_o    [NC];

   int          n_chk = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          n_out = 0;
   logic [65:0] exp_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      localparam int W = cfg_w(g);
      localparam int S = cfg_s(g);

      hls_add_unit_if #(.WIDTH(W)) bus ();

      assign bus.in0       = drv_a[g][W-1:0];
      assign bus.in1       = drv_b[g][W-1:0];
      assign bus.in_valid  = drv_vld[g];
      assign bus.out_ready = drv_ordy[g];
      assign obs_out[g]    = 64'(bus.out);
      assign obs_vld[g]    = bus.out_valid;
      assign obs_rdy[g]    = bus.in_ready;
      assign obs_c[g]      = bus.out_carry;
      assign obs_o[g]      = bus.out_ovf;

      hls_add_unit #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   // Reference: full-width add with one extra bit, overflow from operand and sum sign bits.
   function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask, am, bm, s;
      logic [64:0] full;
      logic        c, o;
      mask = (64'd1 << w) - 64'd1;
      am   = a & mask;
      bm   = b & mask;
      full = {1'b0, am} + {1'b0, bm};
      s    = full[63:0] & mask;
      c    = full[w];
      o    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      return {o, c, s};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock for configuration g: record accepts, score delivered results, end at next negedge.
   task automatic tick(input int g);
      logic [65:0] e;
      #1;
      if (drv_vld[g] && obs_rdy[g]) begin
         exp_q.push_back(model(cfg_w(g), drv_a[g], drv_b[g]));
         n_acc++;
      end
      if (obs_vld[g] && drv_ordy[g]) begin
         n_out++;
         if (exp_q.size() == 0) begin
            chk("sb_spurious_out_valid", 64'(obs_vld[g]), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_sum", obs_out[g], e[63:0]);
            chk("sb_carry", 64'(obs_c[g]), 64'(e[64]));
            chk("sb_ovf", 64'(obs_o[g]), 64'(e[65]));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      for (int g = 0; g < NC; g++) begin
         drv_vld[g]  = 1'b0;
         drv_ordy[g] = 1'b1;
         drv_a[g]    = '0;
         drv_b[g]    = '0;
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1);
   end

   initial begin
      int          acc0;
      int          out0;
      int          cyc;
      int          k;
      int          sel;
      logic [63:0] ea, eb;

      do_reset();
      for (int g = 0; g < NC; g++) begin
         chk("rst_out_valid", 64'(obs_vld[g]), 64'd0);
         chk("rst_in_ready", 64'(obs_rdy[g]), 64'd1);
         chk("rst_out", obs_out[g], 64'd0);
         chk("rst_carry", 64'(obs_c[g]), 64'd0);
         chk("rst_ovf", 64'(obs_o[g]), 64'd0);
      end

      // 32-bit, one stage: 5 + 7
      drv_a[0] = 64'd5; drv_b[0] = 64'd7; drv_vld[0] = 1'b1;
      tick(0);
      drv_vld[0] = 1'b0;
      chk("s1_out_valid", 64'(obs_vld[0]), 64'd1);
      chk("s1_sum", obs_out[0], 64'd12);
      chk("s1_carry", 64'(obs_c[0]), 64'd0);
      chk("s1_ovf", 64'(obs_o[0]), 64'd0);
      tick(0);
      tick(0);

      // 32-bit, two stages: unsigned wrap, then signed overflow, back to back
      drv_a[1] = 64'hFFFF_FFFF; drv_b[1] = 64'd1; drv_vld[1] = 1'b1;
      tick(1);
      chk("s2_not_early", 64'(obs_vld[1]), 64'd0);
      drv_a[1] = 64'h7FFF_FFFF; drv_b[1] = 64'd1;
      tick(1);
      drv_vld[1] = 1'b0;
      chk("s2_wrap_valid", 64'(obs_vld[1]), 64'd1);
      chk("s2_wrap_sum", obs_out[1], 64'd0);
      chk("s2_wrap_carry", 64'(obs_c[1]), 64'd1);
      chk("s2_wrap_ovf", 64'(obs_o[1]), 64'd0);
      tick(1);
      chk("s2_ovf_valid", 64'(obs_vld[1]), 64'd1);
      chk("s2_ovf_sum", obs_out[1], 64'h8000_0000);
      chk("s2_ovf_carry", 64'(obs_c[1]), 64'd0);
      chk("s2_ovf_ovf", 64'(obs_o[1]), 64'd1);
      tick(1);

      // 32-bit, four stages: stream (i, 3i), i = 0..7, results 4i from the fourth cycle on
      for (int c = 0; c < 12; c++) begin
         drv_vld[2] = (c < 8);
         drv_a[2]   = 64'(c);
         drv_b[2]   = 64'(3 * c);
         tick(2);
         if (c >= 3 && c <= 10) begin
            chk("s4_stream_valid", 64'(obs_vld[2]), 64'd1);
            chk("s4_stream_sum", obs_out[2], 64'(4 * (c - 3)));
         end else begin
            chk("s4_stream_bubble", 64'(obs_vld[2]), 64'd0);
         end
      end
      drv_vld[2] = 1'b0;

      // Two stages under backpressure: only two tokens fit
      acc0 = n_acc;
      out0 = n_out;
      drv_ordy[1] = 1'b0;
      drv_vld[1]  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         k = n_acc - acc0;
         drv_a[1] = 64'(100 + k);
         drv_b[1] = 64'(k);
         tick(1);
      end
      chk("bp_accepts", 64'(n_acc - acc0), 64'd2);
      chk("bp_in_ready", 64'(obs_rdy[1]), 64'd0);
      chk("bp_head_valid", 64'(obs_vld[1]), 64'd1);
      chk("bp_head_sum", obs_out[1], 64'd100);
      drv_vld[1]  = 1'b0;
      drv_ordy[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (exp_q.size() != 0) tick(1);
      end
      chk("bp_second_sum", obs_out[1], 64'd102);
      tick(1);
      tick(1);
      chk("bp_outputs", 64'(n_out - out0), 64'd2);
      chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

      // Four stages: reset with three tokens in flight, then a fresh pair
      drv_vld[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drv_a[2] = 64'(1000 + c);
         drv_b[2] = 64'd1;
         tick(2);
      end
      drv_vld[2] = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      chk("mid_rst_out_valid", 64'(obs_vld[2]), 64'd0);
      chk("mid_rst_out", obs_out[2], 64'd0);
      chk("mid_rst_in_ready", 64'(obs_rdy[2]), 64'd1);
      drv_a[2] = 64'd10; drv_b[2] = 64'd20; drv_vld[2] = 1'b1;
      tick(2);
      drv_vld[2] = 1'b0;
      for (int c = 1; c < 4; c++) begin
         chk("mid_rst_latency", 64'(obs_vld[2]), 64'd0);
         tick(2);
      end
      chk("mid_rst_fresh_valid", 64'(obs_vld[2]), 64'd1);
      chk("mid_rst_fresh_sum", obs_out[2], 64'd30);
      for (int c = 0; c < 6; c++) tick(2);

      // Random traffic on the 16-bit and 48-bit builds
      for (int g = 3; g < NC; g++) begin
         do_reset();
         acc0 = n_acc;
         cyc  = 0;
         while ((n_acc - acc0) < 10000 && cyc < 40000) begin
            drv_vld[g]  = ($urandom_range(0, 3) != 0);
            drv_ordy[g] = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 7);
            case (sel)
               0:       ea = '1;
               1:       ea = 64'h0000_8000_8000_0000;
               default: ea = {$urandom, $urandom};
            endcase
            sel = $urandom_range(0, 7);
            case (sel)
               0:       eb = '1;
               1:       eb = 64'h0000_7FFF_FFFF_7FFF;
               default: eb = {$urandom, $urandom};
            endcase
            drv_a[g] = ea;
            drv_b[g] = eb;
            tick(g);
            cyc++;
         end
         chk("rnd_accepts", 64'(n_acc - acc0), 64'd10000);
         drv_vld[g]  = 1'b0;
         drv_ordy[g] = 1'b1;
         for (int c = 0; c < 10; c++) tick(g);
         chk("rnd_drained", 64'(exp_q.size()), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hls_add_unit.md
# hls_add_unit

Pipelined two-operand integer adder, the `add` functional unit the HLS back end instantiates inside generated `*_inner` datapath modules. It accepts one operand pair per cycle through a valid/ready handshake. It returns the sum modulo 2^WIDTH together with carry-out and signed-overflow flags after a fixed latency of STAGES cycles. The carry chain is split evenly across the pipeline stages so that wide adders meet timing.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits; must be ≥ 1 and a multiple of STAGES.
- STAGES, 1, number of pipeline register stages (1–4); this is also the latency in cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- in0  in  WIDTH  operand A.
- in1  in  WIDTH  operand B.
- in_valid  in  1  operand pair present.
- in_ready  out  1  unit can accept the pair this cycle.
- out  out  WIDTH  sum[WIDTH-1:0].
- out_carry  out  1  unsigned carry-out of the full-width add.
- out_ovf  out  1  signed two's-complement overflow.
- out_valid  out  1  out, out_carry and out_ovf are valid.
- out_ready  in  1  downstream consumer accepts the result.

## Operation
- The carry chain is split into STAGES segments of SEG = WIDTH/STAGES bits. Stage k adds bits [k·SEG +: SEG] of both operands plus the carry registered from stage k-1. Stage 0 has carry-in 0.
- Operand bits not yet consumed, and sum bits already produced, travel with the token in pipeline registers.
- Final results:
  - sum = (in0 + in1) mod 2^WIDTH.
  - out_carry = bit WIDTH of the (WIDTH+1)-bit unsigned sum.
  - out_ovf = (in0[MSB] == in1[MSB]) && (sum[MSB] != in0[MSB]).
- Each stage holds one valid bit. Flow control uses a global advance: `adv = !out_valid || out_ready`.
  - When adv = 1, every stage shifts forward by one.
  - When adv = 0, the whole pipeline holds, including data, carries and valid bits.
- in_ready = adv. This is combinational from out_ready and the last-stage valid bit.
- A transfer in occurs when in_valid && in_ready. A transfer out occurs when out_valid && out_ready.
- The handshake has no combinational path from in0/in1 to out. The only combinational path to in_ready is from out_ready.
- Reset (rst = 0 at a rising edge):
  - All valid bits clear; out_valid = 0 the following cycle.
  - out, out_carry and out_ovf = 0.
  - All internal data and carry registers clear.
  - Reset overrides any simultaneous transfer. Tokens in flight are discarded and are not replayed.
- Bubbles are allowed. An idle input cycle produces an out_valid = 0 slot STAGES cycles later, with no compaction.
- When out_valid = 0, outputs retain the last values; consumers must ignore them.

## Timing
- Latency: a pair accepted at edge t appears with out_valid = 1 after edge t+STAGES, when no stall occurs.
- Throughput: one result per cycle while out_ready = 1.
- A stall adds cycles one-for-one and loses no token.
- Simultaneous transfer in and transfer out in the same cycle is legal and keeps full throughput.
- The cycle after reset deasserts: in_ready = 1 and out_valid = 0.
- With in_valid held 1 and out_ready held 0: the unit fills all STAGES slots, then in_ready drops to 0. Capacity is STAGES tokens.

## Structure
- Shared package `hls_fu_pkg` holds:
  - the default WIDTH constant;
  - the MAX_STAGES = 4 constant;
  - a result struct typedef {sum, carry, ovf} reused by the other arithmetic functional units.
- One natural sub-module, `add_seg_stage`: a single SEG-bit adder segment with carry-in, carry-out and its registers, plus an enable. Instantiate it STAGES times with a generate loop.
- An elaboration-time check rejects configurations where WIDTH % STAGES ≠ 0 or STAGES is outside 1–4.

## Test plan
- WIDTH=32, STAGES=1: in0=5, in1=7 → one cycle later out=12, out_carry=0, out_ovf=0.
- WIDTH=32, STAGES=2: in0=0xFFFFFFFF, in1=1 → after 2 cycles out=0, out_carry=1, out_ovf=0. Also in0=0x7FFFFFFF, in1=1 → out=0x80000000, out_ovf=1, out_carry=0.
- Back-to-back stream of 8 pairs (i, 3i) with out_ready=1, STAGES=4 → 8 consecutive results 4i, one per cycle, first one 4 cycles after the first accept.
- Backpressure: out_ready=0 for 6 cycles while in_valid=1, STAGES=2 → in_ready falls after 2 accepts. Results are unchanged and stay in order, and no duplicate or loss occurs after out_ready returns to 1.
- Reset mid-stream: rst=0 with 3 tokens in flight → next cycle out_valid=0, out=0, in_ready=1. After release, a fresh pair 10+20 yields 30 with latency STAGES.
- Random 10k pairs, WIDTH=16 and WIDTH=48, random in_valid/out_ready → scoreboard matches a reference (WIDTH+1)-bit sum and the overflow formula.
